data_bus_xbar: RTL and testbench
================================

Name: data_bus_xbar

Overview:
- Parametrised, registered successor to the CPU's fixed 11-destination data bus.
- Routes any of NUM_SRC byte sources to any of NUM_DST destinations.
- Each destination has its own request/ack channel, waits on per-source valid, and times out after a programmable limit.
- Illegal selectors and timeouts are flagged. Sits between the register file/ALU/memory interface and the control unit.

Parameters:
- WIDTH, 8: data width of every source and destination.
- NUM_SRC, 16: number of sources.
- NUM_DST, 11: number of destination channels.
- SEL_W, 4: selector width. Must satisfy 2**SEL_W >= NUM_SRC.
- TIMEOUT, 15: maximum WAIT cycles before abort. 0 means wait forever.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- src_data  in  NUM_SRC*WIDTH  packed source bytes; source i occupies [i*WIDTH +: WIDTH].
- src_valid  in  NUM_SRC  source i data is usable this cycle.
- dst_sel  in  NUM_DST*SEL_W  per-destination source select, packed like src_data.
- dst_req  in  NUM_DST  per-destination transfer request, level-sampled.
- dst_data  out  NUM_DST*WIDTH  registered destination bytes.
- dst_ack  out  NUM_DST  one-cycle completion pulse.
- dst_err  out  NUM_DST  high with dst_ack when the transfer was aborted.
- dst_busy  out  NUM_DST  channel is in WAIT.
- err_sel  out  1  sticky: illegal selector seen.
- err_timeout  out  1  sticky: timeout seen.
- err_clr  in  1  clears both sticky flags.

Behaviour:
- Reset:
  - All channels go to IDLE; wait counters cleared.
  - All outputs are 0, including dst_data.
  - Reset asserted mid-WAIT aborts the transfer with no ack.
- Per-channel FSM has two states, IDLE and WAIT. Channels are fully independent.
- IDLE with dst_req=1, channel c, selector s:
  - s >= NUM_SRC: next edge dst_data[c] <= 0, dst_ack=1 and dst_err=1 for one cycle, err_sel set. Stays IDLE.
  - src_valid[s]=1: next edge dst_data[c] <= src_data[s], dst_ack=1 for one cycle. Stays IDLE. Latency is 1 cycle.
  - src_valid[s]=0: latch s, counter <= 1, go to WAIT, dst_busy=1.
- WAIT:
  - Uses the latched selector; dst_sel and dst_req are ignored.
  - Data is sampled in the cycle src_valid is seen, not at request time.
  - src_valid[s]=1: capture on that edge, ack next cycle, go to IDLE.
  - Otherwise, if TIMEOUT != 0 and counter == TIMEOUT: go to IDLE, dst_data holds its old value, dst_ack=1 and dst_err=1, err_timeout set. Otherwise counter increments.
  - Valid arriving in the same cycle as the timeout wins: normal capture, no error.
- Back-to-back transfers:
  - During an ack cycle the FSM is already IDLE, so a new dst_req is accepted. Sustained throughput is one transfer per cycle per channel.
  - dst_req held high issues a new transfer every cycle.
- Fan-out: several channels may select the same source in the same cycle; all capture identical data. There is no arbitration or contention.
- Hold: dst_data changes only on a successful capture or an illegal-selector completion.
- Sticky flags: set-on-event. err_clr clears them, but a set event in the same cycle wins over err_clr.
- Counter width is clog2(TIMEOUT+1) and the counter never wraps.

Decomposition:
- Package bus_pkg holds:
  - the channel state encoding (IDLE=0, WAIT=1);
  - source index constants for the CPU instance (SRC_ZERO=0, SRC_PC=1, SRC_SP=2, SRC_ADD=3, SRC_X=4, SRC_Y=5, SRC_STAT=6, SRC_MEM=7, SRC_IMM=8, SRC_FETCH=9, SRC_DECODE=10, SRC_ALU=11, SRC_ONE=12);
  - destination index constants (DST_PC=0 .. DST_ALU1=10).
- One sub-module, data_bus_chan: FSM, counter, source mux and output register for a single destination.
- Top-level data_bus_xbar generates NUM_DST instances and ORs their error events into the sticky flags.

Test Plan:
- Immediate transfer: src 4 = 0x5A with valid=1, req ch2 sel=4 at cycle T -> T+1: dst_data[2]=0x5A, ack[2]=1, err[2]=0, busy[2]=0.
- Wait path: sel=7, valid[7]=0 for 3 cycles, then valid with 0xC3 -> busy[ch] high for 3 cycles, capture 0xC3, ack one cycle after valid.
- Timeout (TIMEOUT=15): valid never asserted -> ack=1 and err=1 exactly 15 cycles after entering WAIT, dst_data unchanged, err_timeout=1. Then err_clr -> flag clears. Timeout coincident with err_clr -> flag stays 1.
- Illegal selector (NUM_SRC=13): sel=14 -> next cycle dst_data=0x00, ack=1, err=1, err_sel=1. Also: valid arriving on the counter==TIMEOUT cycle -> capture, err=0.
- Back-to-back and fan-out: req held on ch0 with sel 1,2,3 over consecutive cycles -> three consecutive acks with matching data. Ch0 and ch5 both sel=11 in the same cycle -> both capture the ALU byte.
- Reset mid-WAIT: assert reset during WAIT -> all outputs 0 immediately, no ack. After release, a new request completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the CPU data bus crossbar: channel state encoding
// and the source/destination index map of the CPU instance.
package bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } chan_state_e;

    // Source indices as wired in the CPU
    localparam int unsigned SRC_ZERO   = 0;
    localparam int unsigned SRC_PC     = 1;
    localparam int unsigned SRC_SP     = 2;
    localparam int unsigned SRC_ADD    = 3;
    localparam int unsigned SRC_X      = 4;
    localparam int unsigned SRC_Y      = 5;
    localparam int unsigned SRC_STAT   = 6;
    localparam int unsigned SRC_MEM    = 7;
    localparam int unsigned SRC_IMM    = 8;
    localparam int unsigned SRC_FETCH  = 9;
    localparam int unsigned SRC_DECODE = 10;
    localparam int unsigned SRC_ALU    = 11;
    localparam int unsigned SRC_ONE    = 12;

    // Destination channel indices
    localparam int unsigned DST_PC    = 0;
    localparam int unsigned DST_SP    = 1;
    localparam int unsigned DST_ADDR  = 2;
    localparam int unsigned DST_X     = 3;
    localparam int unsigned DST_Y     = 4;
    localparam int unsigned DST_STAT  = 5;
    localparam int unsigned DST_MEM   = 6;
    localparam int unsigned DST_IMM   = 7;
    localparam int unsigned DST_CTRL  = 8;
    localparam int unsigned DST_ALU0  = 9;
    localparam int unsigned DST_ALU1  = 10;

endpackage

// File: rtl/data_bus_chan.sv
// One destination channel of the data bus crossbar: source mux, IDLE/WAIT
// handshake FSM with timeout counter, and the registered output byte.
module data_bus_chan
    import bus_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_SRC = 16,
    parameter int SEL_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]       src_valid,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     req,
    output logic [WIDTH-1:0]         data,
    output logic                     ack,
    output logic                     err,
    output logic                     busy,
    output logic                     sel_evt,
    output logic                     timeout_evt
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;

    logic [SEL_W-1:0] cur_sel;
    logic [WIDTH-1:0] cur_byte;
    logic             cur_valid;
    logic             cur_legal;

    // A selector is legal only if it matches an existing source.
    assign cur_sel = (state_q == WAIT) ? sel_q : sel;

    always_comb begin
        cur_byte  = '0;
        cur_valid = 1'b0;
        cur_legal = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cur_sel == SEL_W'(i)) begin
                cur_byte  = src_data[i*WIDTH +: WIDTH];
                cur_valid = src_valid[i];
                cur_legal = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        data_d      = data_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        sel_evt     = 1'b0;
        timeout_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (!cur_legal) begin
                        data_d  = '0;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        sel_evt = 1'b1;
                    end else if (cur_valid) begin
                        data_d = cur_byte;
                        ack_d  = 1'b1;
                    end else begin
                        sel_d   = sel;
                        cnt_d   = CNT_W'(1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // Valid beats the timeout when both land in the same cycle.
                if (cur_valid) begin
                    data_d  = cur_byte;
                    ack_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LIMIT)) begin
                    ack_d       = 1'b1;
                    err_d       = 1'b1;
                    timeout_evt = 1'b1;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign data = data_q;
    assign ack  = ack_q;
    assign err  = err_q;
    assign busy = (state_q == WAIT);

endmodule

// File: rtl/data_bus_xbar.sv
// Registered data bus crossbar: NUM_SRC byte sources routed to NUM_DST
// independent request/ack destination channels with sticky error flags.
module data_bus_xbar
    import bus_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_SRC = 16,
    parameter int NUM_DST = 11,
    parameter int SEL_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]       src_valid,
    input  logic [NUM_DST*SEL_W-1:0] dst_sel,
    input  logic [NUM_DST-1:0]       dst_req,
    output logic [NUM_DST*WIDTH-1:0] dst_data,
    output logic [NUM_DST-1:0]       dst_ack,
    output logic [NUM_DST-1:0]       dst_err,
    output logic [NUM_DST-1:0]       dst_busy,
    output logic                     err_sel,
    output logic                     err_timeout,
    input  logic                     err_clr
);

    logic [NUM_DST-1:0] sel_evt;
    logic [NUM_DST-1:0] timeout_evt;

    for (genvar c = 0; c < NUM_DST; c++) begin : g_chan
        data_bus_chan #(
            .WIDTH   (WIDTH),
            .NUM_SRC (NUM_SRC),
            .SEL_W   (SEL_W),
            .TIMEOUT (TIMEOUT)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .src_data    (src_data),
            .src_valid   (src_valid),
            .sel         (dst_sel[c*SEL_W +: SEL_W]),
            .req         (dst_req[c]),
            .data        (dst_data[c*WIDTH +: WIDTH]),
            .ack         (dst_ack[c]),
            .err         (dst_err[c]),
            .busy        (dst_busy[c]),
            .sel_evt     (sel_evt[c]),
            .timeout_evt (timeout_evt[c])
        );
    end

    // A new error event takes priority over a clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_sel     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (|sel_evt)
                err_sel <= 1'b1;
            else if (err_clr)
                err_sel <= 1'b0;
            if (|timeout_evt)
                err_timeout <= 1'b1;
            else if (err_clr)
                err_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_bus_xbar.sv
// Self-checking bench for data_bus_xbar: table-driven single-cycle transfers,
// hand-written WAIT/timeout/reset sequences and an ack scoreboard.
module tb_data_bus_xbar;
    import bus_pkg::*;

    localparam int WIDTH   = 8;
    localparam int NUM_SRC = 13;
    localparam int NUM_DST = 11;
    localparam int SEL_W   = 4;
    localparam int TIMEOUT = 15;
    localparam int NV      = 9;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]       src_valid;
    logic [NUM_DST*SEL_W-1:0] dst_sel;
    logic [NUM_DST-1:0]       dst_req;
    logic [NUM_DST*WIDTH-1:0] dst_data;
    logic [NUM_DST-1:0]       dst_ack;
    logic [NUM_DST-1:0]       dst_err;
    logic [NUM_DST-1:0]       dst_busy;
    logic                     err_sel;
    logic                     err_timeout;
    logic                     err_clr;

    typedef struct {
        int         ch;
        logic [7:0] data;
        logic       err;
    } exp_t;

    typedef struct {
        int         ch;
        int         sel;
        logic [7:0] src_val;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[NV];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    logic exp_err_sel;

    data_bus_xbar #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC),
        .NUM_DST (NUM_DST),
        .SEL_W   (SEL_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .src_data    (src_data),
        .src_valid   (src_valid),
        .dst_sel     (dst_sel),
        .dst_req     (dst_req),
        .dst_data    (dst_data),
        .dst_ack     (dst_ack),
        .dst_err     (dst_err),
        .dst_busy    (dst_busy),
        .err_sel     (err_sel),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    // Every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int c = 0; c < NUM_DST; c++) begin
                if (dst_ack[c]) begin
                    n_vec++;
                    if (sb_q.size() == 0) begin
                        n_bad++;
                        $display("[TB] FAIL sb_unexpected_ack ch%0d: got data=%h err=%b, required no ack",
                                 c, dst_data[c*WIDTH +: WIDTH], dst_err[c]);
                    end else begin
                        mon_e = sb_q.pop_front();
                        if (mon_e.ch != c || mon_e.data !== dst_data[c*WIDTH +: WIDTH] ||
                            mon_e.err !== dst_err[c]) begin
                            n_bad++;
                            $display("[TB] FAIL sb_ack: got ch%0d data=%h err=%b, required ch%0d data=%h err=%b",
                                     c, dst_data[c*WIDTH +: WIDTH], dst_err[c],
                                     mon_e.ch, mon_e.data, mon_e.err);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int ch, input int sel, input logic req);
        dst_sel[ch*SEL_W +: SEL_W] = SEL_W'(sel);
        dst_req[ch]                = req;
    endtask

    task automatic setSource(input int s, input logic [7:0] val, input logic v);
        src_data[s*WIDTH +: WIDTH] = val;
        src_valid[s]               = v;
    endtask

    // Channel 6 waits on SRC_IMM; the last WAIT cycle can carry err_clr or valid.
    task automatic timeoutSeq(input logic clr_last, input logic valid_last,
                              input logic [7:0] exp_data, input logic exp_err,
                              input logic exp_flag);
        setSource(SRC_IMM, 8'h00, 1'b0);
        applyStimulus(6, SRC_IMM, 1'b1);
        sb_q.push_back('{6, exp_data, exp_err});
        tick();
        applyStimulus(6, SRC_IMM, 1'b0);
        for (int k = 0; k < TIMEOUT - 1; k++) begin
            checkOutput($sformatf("to_wait%0d", k), {30'd0, dst_busy[6], dst_ack[6]}, 32'd2);
            tick();
        end
        checkOutput("to_last_wait", {30'd0, dst_busy[6], dst_ack[6]}, 32'd2);
        err_clr = clr_last;
        if (valid_last)
            setSource(SRC_IMM, 8'hE7, 1'b1);
        tick();
        err_clr = 1'b0;
        checkOutput("to_ack", {31'd0, dst_ack[6]}, 32'd1);
        checkOutput("to_err", {31'd0, dst_err[6]}, {31'd0, exp_err});
        checkOutput("to_data", {24'd0, dst_data[6*WIDTH +: WIDTH]}, {24'd0, exp_data});
        checkOutput("to_busy", {31'd0, dst_busy[6]}, 32'd0);
        checkOutput("to_flag", {31'd0, err_timeout}, {31'd0, exp_flag});
        setSource(SRC_IMM, 8'h00, 1'b0);
    endtask

    initial begin
        vecs[0] = '{2, 4,  8'h5A, 8'h5A, 1'b0};
        vecs[1] = '{0, 1,  8'h11, 8'h11, 1'b0};
        vecs[2] = '{0, 2,  8'h22, 8'h22, 1'b0};
        vecs[3] = '{0, 3,  8'h33, 8'h33, 1'b0};
        vecs[4] = '{7, 5,  8'hA5, 8'hA5, 1'b0};
        vecs[5] = '{7, 14, 8'hFF, 8'h00, 1'b1};
        vecs[6] = '{8, 12, 8'h7E, 8'h7E, 1'b0};
        vecs[7] = '{8, 13, 8'hFF, 8'h00, 1'b1};
        vecs[8] = '{6, 9,  8'h66, 8'h66, 1'b0};

        reset     = 1'b1;
        src_data  = '0;
        src_valid = '1;
        dst_sel   = '0;
        dst_req   = '0;
        err_clr   = 1'b0;
        exp_err_sel = 1'b0;
        #1;
        checkOutput("rst_data_zero", {31'd0, (dst_data == '0)}, 32'd1);
        checkOutput("rst_ack_err_busy", {dst_ack, dst_err, dst_busy}, 32'd0);
        checkOutput("rst_flags", {30'd0, err_sel, err_timeout}, 32'd0);
        tick();
        tick();
        reset  = 1'b0;
        mon_en = 1'b1;

        // Single-cycle transfers; consecutive rows on one channel keep req high.
        for (int i = 0; i < NV; i++) begin
            dst_req = '0;
            if (vecs[i].sel < NUM_SRC)
                setSource(vecs[i].sel, vecs[i].src_val, 1'b1);
            applyStimulus(vecs[i].ch, vecs[i].sel, 1'b1);
            sb_q.push_back('{vecs[i].ch, vecs[i].exp_data, vecs[i].exp_err});
            if (vecs[i].exp_err)
                exp_err_sel = 1'b1;
            tick();
            checkOutput($sformatf("vec%0d_data", i),
                        {24'd0, dst_data[vecs[i].ch*WIDTH +: WIDTH]}, {24'd0, vecs[i].exp_data});
            checkOutput($sformatf("vec%0d_ack_err_busy", i),
                        {29'd0, dst_ack[vecs[i].ch], dst_err[vecs[i].ch], dst_busy[vecs[i].ch]},
                        {29'd0, 1'b1, vecs[i].exp_err, 1'b0});
            checkOutput($sformatf("vec%0d_err_sel", i), {31'd0, err_sel}, {31'd0, exp_err_sel});
        end
        dst_req = '0;
        tick();
        checkOutput("hold_ch2", {24'd0, dst_data[2*WIDTH +: WIDTH]}, 32'h5A);
        checkOutput("no_ack_idle", {21'd0, dst_ack}, 32'd0);

        // Fan-out: two channels pick the ALU byte in the same cycle
        setSource(SRC_ALU, 8'h9C, 1'b1);
        applyStimulus(0, SRC_ALU, 1'b1);
        applyStimulus(5, SRC_ALU, 1'b1);
        sb_q.push_back('{0, 8'h9C, 1'b0});
        sb_q.push_back('{5, 8'h9C, 1'b0});
        tick();
        dst_req = '0;
        checkOutput("fan_ch0", {24'd0, dst_data[0 +: WIDTH]}, 32'h9C);
        checkOutput("fan_ch5", {24'd0, dst_data[5*WIDTH +: WIDTH]}, 32'h9C);

        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("err_sel_clr", {31'd0, err_sel}, 32'd0);

        // Wait path: data is taken when valid shows up, not at request time
        setSource(SRC_MEM, 8'h11, 1'b0);
        applyStimulus(3, SRC_MEM, 1'b1);
        sb_q.push_back('{3, 8'hC3, 1'b0});
        for (int k = 0; k < 3; k++) begin
            tick();
            applyStimulus(3, SRC_X, 1'b0);
            checkOutput($sformatf("wait_busy%0d", k), {30'd0, dst_busy[3], dst_ack[3]}, 32'd2);
        end
        setSource(SRC_MEM, 8'hC3, 1'b1);
        tick();
        setSource(SRC_MEM, 8'h00, 1'b0);
        checkOutput("wait_ack", {30'd0, dst_ack[3], dst_err[3]}, 32'd2);
        checkOutput("wait_data", {24'd0, dst_data[3*WIDTH +: WIDTH]}, 32'hC3);
        checkOutput("wait_busy_done", {31'd0, dst_busy[3]}, 32'd0);

        timeoutSeq(1'b0, 1'b0, 8'h66, 1'b1, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("to_flag_clr", {31'd0, err_timeout}, 32'd0);
        timeoutSeq(1'b1, 1'b0, 8'h66, 1'b1, 1'b1);
        timeoutSeq(1'b0, 1'b1, 8'hE7, 1'b0, 1'b1);

        for (int k = 0; k < 5 && sb_q.size() != 0; k++)
            tick();
        checkOutput("sb_drain", sb_q.size(), 32'd0);

        // Reset in the middle of a WAIT: outputs clear at once, no ack follows
        setSource(SRC_DECODE, 8'h00, 1'b0);
        applyStimulus(4, SRC_DECODE, 1'b1);
        tick();
        applyStimulus(4, SRC_DECODE, 1'b0);
        checkOutput("rst_wait_busy", {31'd0, dst_busy[4]}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("rstw_data_zero", {31'd0, (dst_data == '0)}, 32'd1);
        checkOutput("rstw_ack_err_busy", {dst_ack, dst_err, dst_busy}, 32'd0);
        checkOutput("rstw_flags", {30'd0, err_sel, err_timeout}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        checkOutput("post_rst_idle", {30'd0, dst_busy[4], dst_ack[4]}, 32'd0);
        setSource(SRC_DECODE, 8'h4D, 1'b1);
        applyStimulus(4, SRC_DECODE, 1'b1);
        sb_q.push_back('{4, 8'h4D, 1'b0});
        tick();
        dst_req = '0;
        checkOutput("post_rst_ack", {31'd0, dst_ack[4]}, 32'd1);
        checkOutput("post_rst_data", {24'd0, dst_data[4*WIDTH +: WIDTH]}, 32'h4D);

        for (int k = 0; k < 5 && sb_q.size() != 0; k++)
            tick();
        tick();
        checkOutput("sb_final_drain", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
